// File: rtl/mips_pkg.sv
// mips_pkg: shared opcodes, control vectors and field positions for the pipeline
package mips_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;
  localparam int M_BRANCH    = 2;
  localparam int M_MEMREAD   = 1;
  localparam int M_MEMWRITE  = 0;
  localparam int EX_REGDST   = 3;
  localparam int EX_ALUOP_LO = 1;
  localparam int EX_ALUSRC   = 0;
  typedef struct packed {
    logic [1:0] wb;
    logic [2:0] m;
    logic [3:0] ex;
  } ctl_t;
  localparam ctl_t CTL_RTYPE = '{wb: 2'b10, m: 3'b000, ex: 4'b1100};
  localparam ctl_t CTL_LW    = '{wb: 2'b11, m: 3'b010, ex: 4'b0001};
  localparam ctl_t CTL_SW    = '{wb: 2'b00, m: 3'b001, ex: 4'b0001};
  localparam ctl_t CTL_BEQ   = '{wb: 2'b00, m: 3'b100, ex: 4'b0010};
  localparam ctl_t CTL_NOP   = '{wb: 2'b00, m: 3'b000, ex: 4'b0000};
  function automatic ctl_t decode_ctl(input logic [5:0] op);
    return op == OP_RTYPE ? CTL_RTYPE :
           op == OP_LW    ? CTL_LW    :
           op == OP_SW    ? CTL_SW    :
           op == OP_BEQ   ? CTL_BEQ   : CTL_NOP;
  endfunction
  // rt is a source operand only for these formats; for lw it is the destination
  function automatic logic reads_rt(input logic [5:0] op);
    return op == OP_RTYPE || op == OP_SW || op == OP_BEQ;
  endfunction
endpackage

// File: rtl/regfile_32x32.sv
// regfile_32x32: 2R1W register file with WB write-through bypass and async clear
module regfile_32x32 (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0][31:0] mem;
  logic wr;
  assign wr = we && wa != 5'd0;
  // storage: cleared while rst is low, $0 never written
  always_ff @(posedge clk or negedge rst)
    if (!rst) mem <= '0;
    else if (wr) mem[wa] <= wd;
  // read ports: reset and $0 read zero, a pending WB write is forwarded
  always_comb begin
    rd1 = (!rst || ra1 == 5'd0) ? '0 : (wr && wa == ra1) ? wd : mem[ra1];
    rd2 = (!rst || ra2 == 5'd0) ? '0 : (wr && wa == ra2) ? wd : mem[ra2];
  end
endmodule

// File: rtl/id_decode_stage.sv
// id_decode_stage: MIPS ID stage - decode, register read, sign extension, load-use stall
module id_decode_stage
  import mips_pkg::*;
#(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            instr,
  input  logic [31:0]            npc_in,
  input  logic                   wb_regwrite,
  input  logic [4:0]             wb_writereg,
  input  logic [31:0]            wb_writedata,
  input  logic                   idex_memread,
  input  logic [4:0]             idex_rt,
  output logic [1:0]             ctlwb_out,
  output logic [2:0]             ctlm_out,
  output logic [3:0]             ctlex_out,
  output logic [31:0]            npc,
  output logic [31:0]            readdat1,
  output logic [31:0]            readdat2,
  output logic [31:0]            signext_out,
  output logic [4:0]             instr_2016,
  output logic [4:0]             instr_1511,
  output logic                   stall,
  output logic [STALL_CNT_W-1:0] stall_count
);
  logic [5:0] op;
  logic [4:0] rs;
  ctl_t       ctl;
  logic       bubble;
  assign op          = instr[31:26];
  assign rs          = instr[25:21];
  assign instr_2016  = instr[20:16];
  assign instr_1511  = instr[15:11];
  assign npc         = npc_in;
  assign signext_out = {{16{instr[15]}}, instr[15:0]};
  regfile_32x32 u_rf (
    .clk (clk),
    .rst (rst),
    .ra1 (rs),
    .ra2 (instr_2016),
    .we  (wb_regwrite),
    .wa  (wb_writereg),
    .wd  (wb_writedata),
    .rd1 (readdat1),
    .rd2 (readdat2)
  );
  // decode and load-use detection; a stall or reset turns the controls into a bubble
  always_comb begin
    ctl       = decode_ctl(op);
    stall     = rst && idex_memread && idex_rt != 5'd0 &&
                (idex_rt == rs || (idex_rt == instr_2016 && reads_rt(op)));
    bubble    = stall || !rst;
    ctlwb_out = bubble ? '0 : ctl.wb;
    ctlm_out  = bubble ? '0 : ctl.m;
    ctlex_out = bubble ? '0 : ctl.ex;
  end
  // saturating count of stall cycles
  always_ff @(posedge clk or negedge rst)
    if (!rst) stall_count <= '0;
    else if (stall && stall_count != '1) stall_count <= stall_count + 1'b1;
endmodule

// File: tb/tb_id_decode_stage.sv
// tb_id_decode_stage: directed self-checking bench for the ID stage
module tb_id_decode_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr, npc_in, wb_writedata;
  logic        wb_regwrite, idex_memread;
  logic [4:0]  wb_writereg, idex_rt;
  logic [1:0]  ctlwb_out, d2_ctlwb;
  logic [2:0]  ctlm_out, d2_ctlm;
  logic [3:0]  ctlex_out, d2_ctlex;
  logic [31:0] npc, readdat1, readdat2, signext_out;
  logic [31:0] d2_npc, d2_rd1, d2_rd2, d2_sext;
  logic [4:0]  instr_2016, instr_1511, d2_2016, d2_1511;
  logic        stall, d2_stall;
  logic [15:0] stall_count;
  logic [1:0]  d2_count;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_decode_stage dut (
    .clk(clk), .rst(rst), .instr(instr), .npc_in(npc_in),
    .wb_regwrite(wb_regwrite), .wb_writereg(wb_writereg), .wb_writedata(wb_writedata),
    .idex_memread(idex_memread), .idex_rt(idex_rt),
    .ctlwb_out(ctlwb_out), .ctlm_out(ctlm_out), .ctlex_out(ctlex_out),
    .npc(npc), .readdat1(readdat1), .readdat2(readdat2), .signext_out(signext_out),
    .instr_2016(instr_2016), .instr_1511(instr_1511),
    .stall(stall), .stall_count(stall_count)
  );

  id_decode_stage #(.STALL_CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .instr(instr), .npc_in(npc_in),
    .wb_regwrite(wb_regwrite), .wb_writereg(wb_writereg), .wb_writedata(wb_writedata),
    .idex_memread(idex_memread), .idex_rt(idex_rt),
    .ctlwb_out(d2_ctlwb), .ctlm_out(d2_ctlm), .ctlex_out(d2_ctlex),
    .npc(d2_npc), .readdat1(d2_rd1), .readdat2(d2_rd2), .signext_out(d2_sext),
    .instr_2016(d2_2016), .instr_1511(d2_1511),
    .stall(d2_stall), .stall_count(d2_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ctl(input string tag, input logic [3:0] ex, input logic [2:0] m, input logic [1:0] wb);
    chk({tag, "_ex"}, {28'd0, ctlex_out}, {28'd0, ex});
    chk({tag, "_m"},  {29'd0, ctlm_out},  {29'd0, m});
    chk({tag, "_wb"}, {30'd0, ctlwb_out}, {30'd0, wb});
  endtask

  initial begin
    rst = 1'b0; instr = 32'h8C220004; npc_in = 32'h0000_0104;
    wb_regwrite = 1'b0; wb_writereg = 5'd0; wb_writedata = 32'd0;
    idex_memread = 1'b1; idex_rt = 5'd1;
    tick; tick;
    chk_ctl("rst_ctl", 4'b0000, 3'b000, 2'b00);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_rd1", readdat1, 32'd0);
    chk("rst_rd2", readdat2, 32'd0);
    chk("rst_cnt", {16'd0, stall_count}, 32'd0);
    chk("rst_npc", npc, 32'h0000_0104);
    chk("rst_sext", signext_out, 32'h0000_0004);
    chk("rst_2016", {27'd0, instr_2016}, 32'd2);
    idex_memread = 1'b0; idex_rt = 5'd0;
    rst = 1'b1; #1;
    chk_ctl("lw", 4'b0001, 3'b010, 2'b11);
    chk("lw_sext", signext_out, 32'h0000_0004);
    tick;
    wb_regwrite = 1'b1; wb_writereg = 5'd5; wb_writedata = 32'hDEADBEEF;
    instr = 32'h00A63020; #1;
    chk("wr5_bypass", readdat1, 32'hDEADBEEF);
    tick;
    wb_regwrite = 1'b0; #1;
    chk("wr5_rd1", readdat1, 32'hDEADBEEF);
    chk("wr5_rd2", readdat2, 32'd0);
    chk_ctl("add", 4'b1100, 3'b000, 2'b10);
    chk("add_1511", {27'd0, instr_1511}, 32'd6);
    wb_regwrite = 1'b1; wb_writereg = 5'd0; wb_writedata = 32'hFFFFFFFF;
    instr = 32'h00000020; #1;
    chk("r0_bypass", readdat1, 32'd0);
    tick;
    wb_regwrite = 1'b0; #1;
    chk("r0_rd1", readdat1, 32'd0);
    chk("r0_rd2", readdat2, 32'd0);
    wb_regwrite = 1'b1; wb_writereg = 5'd7; wb_writedata = 32'h12345678;
    instr = 32'h00E54020; #1;
    chk("byp_rd1", readdat1, 32'h12345678);
    chk("byp_rd2_other", readdat2, 32'hDEADBEEF);
    instr = 32'h00A73020; #1;
    chk("byp_rd1_other", readdat1, 32'hDEADBEEF);
    chk("byp_rd2", readdat2, 32'h12345678);
    tick;
    wb_regwrite = 1'b0; #1;
    chk("r7_stored", readdat2, 32'h12345678);
    instr = 32'h00421820; idex_memread = 1'b1; idex_rt = 5'd2;
    wb_regwrite = 1'b1; wb_writereg = 5'd9; wb_writedata = 32'hA5A5A5A5; #1;
    chk("lu_stall", {31'd0, stall}, 32'd1);
    chk_ctl("lu_bubble", 4'b0000, 3'b000, 2'b00);
    chk("lu_cnt0", {16'd0, stall_count}, 32'd0);
    chk("lu_1511", {27'd0, instr_1511}, 32'd3);
    tick;
    wb_regwrite = 1'b0; idex_memread = 1'b0; #1;
    chk("lu_cnt1", {16'd0, stall_count}, 32'd1);
    chk("lu_release", {31'd0, stall}, 32'd0);
    chk_ctl("lu_issue", 4'b1100, 3'b000, 2'b10);
    instr = 32'h01200020; #1;
    chk("stall_wr9", readdat1, 32'hA5A5A5A5);
    idex_memread = 1'b1; idex_rt = 5'd0; instr = 32'h00000020; #1;
    chk("nf_rt0", {31'd0, stall}, 32'd0);
    idex_rt = 5'd2; instr = 32'h8C220004; #1;
    chk("nf_lw_rt", {31'd0, stall}, 32'd0);
    chk("nf_lw_m", {29'd0, ctlm_out}, 32'd2);
    instr = 32'hAC220004; #1;
    chk("sw_rt_stall", {31'd0, stall}, 32'd1);
    chk("sw_bubble_m", {29'd0, ctlm_out}, 32'd0);
    instr = 32'h8C228000; #1;
    chk("sext_neg", signext_out, 32'hFFFF8000);
    idex_memread = 1'b0;
    tick;
    chk("cnt_hold", {16'd0, stall_count}, 32'd1);
    instr = 32'h01200020;
    rst = 1'b0; wb_regwrite = 1'b1; wb_writereg = 5'd9; wb_writedata = 32'hFFFFFFFF; #1;
    chk("async_cnt", {16'd0, stall_count}, 32'd0);
    chk("async_cnt2", {30'd0, d2_count}, 32'd0);
    tick;
    rst = 1'b1; wb_regwrite = 1'b0; #1;
    chk("rst_wins_wr", readdat1, 32'd0);
    instr = 32'h00421820; idex_memread = 1'b1; idex_rt = 5'd2;
    repeat (5) tick;
    chk("sat_w2", {30'd0, d2_count}, 32'd3);
    chk("sat_w16", {16'd0, stall_count}, 32'd5);
    chk("sat_stall", {31'd0, stall}, 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
